// File: rtl/plot_pkg.sv
// plot_pkg: shared defaults and types for the scatter-plot frame scheduler.
//   NUM_SAMPLES - samples per run (one per plot column)
//   SAMPLE_W    - sample value width in bits
//   COL_W       - column index width (covers NUM_SAMPLES-1)
//   MAX_VAL     - largest plottable value; larger samples are clamped
//   plot_state_e - scheduler states
package plot_pkg;

  localparam int unsigned NUM_SAMPLES = 300;
  localparam int unsigned SAMPLE_W    = 5;
  localparam int unsigned COL_W       = 9;
  localparam int unsigned MAX_VAL     = 29;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StArmed
  } plot_state_e;

endpackage

// File: rtl/plot_sample_bank.sv
// plot_sample_bank: simple dual-port sample RAM, one synchronous write port and one
// synchronous read port with 1-cycle latency. Contents are never reset.
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   re_i    - read enable; rdata_o holds its last value when low
//   raddr_i - read address
//   rdata_o - registered read data
module plot_sample_bank #(
  parameter int unsigned Depth = 300,
  parameter int unsigned Width = 5,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/plot_frame_scheduler.sv
// plot_frame_scheduler: frame-synchronous double-buffer scheduler for the scatter plot.
// A run of NUM_SAMPLES samples is captured into the back bank; the banks swap only on
// frame_start once the run is complete, so the renderer never sees a half-written run.
//   CLK100MHZ   - system clock
//   rst_n       - synchronous active-low reset
//   frame_start - one-cycle pulse at start of vertical blank
//   run_req     - request to capture a new run (honoured in IDLE only)
//   src_data/src_valid/src_ready - upstream sample handshake
//   rd_col      - renderer column index
//   rd_data/rd_valid - front-bank sample, 1-cycle latency
//   busy        - high while filling or armed
//   swap_pulse  - one-cycle pulse on the buffer swap
//   run_count   - completed (swapped) runs, wraps
// Build option: define PLOT_AUTO_RUN_EN to start a new run automatically after reset
// and after every swap (continuous refresh).
module plot_frame_scheduler
  import plot_pkg::*;
#(
  parameter int unsigned NumSamples = NUM_SAMPLES,
  parameter int unsigned SampleW    = SAMPLE_W,
  parameter int unsigned ColW       = COL_W,
  parameter int unsigned MaxVal     = MAX_VAL
) (
  input  logic               CLK100MHZ,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               run_req,
  input  logic [SampleW-1:0] src_data,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [ColW-1:0]    rd_col,
  output logic [SampleW-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               swap_pulse,
  output logic [7:0]         run_count
);

  localparam logic [ColW-1:0]    LastIdx = ColW'(NumSamples - 1);
  localparam logic [ColW-1:0]    ColLim  = ColW'(NumSamples);
  localparam logic [SampleW-1:0] ClampV  = SampleW'(MaxVal);

  plot_state_e        state_q, state_d;
  logic [ColW-1:0]    wr_idx_q, wr_idx_d;
  logic               bank_sel_q, bank_sel_d;  // front bank; back bank is ~bank_sel_q
  logic               loaded_q, loaded_d;
  logic [7:0]         run_count_q, run_count_d;
  logic               rd_valid_q;
  logic               rd_sel_q;                // bank_sel aligned with RAM read latency
  logic               start_req;
  logic               accept;
  logic               rd_hit;
  logic [SampleW-1:0] wdata;
  logic [SampleW-1:0] rdata0, rdata1;

`ifdef PLOT_AUTO_RUN_EN
  // Resets high so the first cycle after reset release requests a run.
  logic auto_req_q;

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      auto_req_q <= 1'b1;
    end else begin
      auto_req_q <= swap_pulse;
    end
  end

  assign start_req = run_req | auto_req_q;
`else
  assign start_req = run_req;
`endif

  assign src_ready = (state_q == StFill);
  assign busy      = (state_q != StIdle);
  assign accept    = src_valid && src_ready;
  assign wdata     = (src_data > ClampV) ? ClampV : src_data;
  assign rd_hit    = (rd_col < ColLim) && loaded_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    bank_sel_d  = bank_sel_q;
    loaded_d    = loaded_q;
    run_count_d = run_count_q;
    swap_pulse  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d  = StFill;
          wr_idx_d = '0;
        end
      end
      StFill: begin
        // frame_start is deliberately ignored here, including on the last write.
        if (src_valid) begin
          if (wr_idx_q == LastIdx) begin
            state_d  = StArmed;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StArmed: begin
        if (frame_start) begin
          swap_pulse  = 1'b1;
          bank_sel_d  = ~bank_sel_q;
          loaded_d    = 1'b1;
          run_count_d = run_count_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      bank_sel_q  <= 1'b0;
      loaded_q    <= 1'b0;
      run_count_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      bank_sel_q  <= bank_sel_d;
      loaded_q    <= loaded_d;
      run_count_q <= run_count_d;
      rd_valid_q  <= rd_hit;
      // Captured with the pre-swap bank_sel, so a read on the swap cycle sees the old front.
      rd_sel_q    <= bank_sel_q;
    end
  end

  plot_sample_bank #(
    .Depth(NumSamples),
    .Width(SampleW),
    .AddrW(ColW)
  ) u_bank0 (
    .clk_i  (CLK100MHZ),
    .we_i   (accept && bank_sel_q),
    .waddr_i(wr_idx_q),
    .wdata_i(wdata),
    .re_i   (rd_hit),
    .raddr_i(rd_col),
    .rdata_o(rdata0)
  );

  plot_sample_bank #(
    .Depth(NumSamples),
    .Width(SampleW),
    .AddrW(ColW)
  ) u_bank1 (
    .clk_i  (CLK100MHZ),
    .we_i   (accept && !bank_sel_q),
    .waddr_i(wr_idx_q),
    .wdata_i(wdata),
    .re_i   (rd_hit),
    .raddr_i(rd_col),
    .rdata_o(rdata1)
  );

  assign rd_data   = rd_valid_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
  assign rd_valid  = rd_valid_q;
  assign run_count = run_count_q;

endmodule

// File: tb/tb_plot_frame_scheduler.sv
// tb_plot_frame_scheduler: directed sequence with randomized data, stalls, stray
// frame_start/run_req pulses and read columns, checked against a two-array
// (displayed run / pending run) reference model.
module tb_plot_frame_scheduler;

  localparam int N    = 300;
  localparam int MAXV = 29;

  logic       CLK100MHZ = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       run_req = 1'b0;
  logic [4:0] src_data = '0;
  logic       src_valid = 1'b0;
  logic [8:0] rd_col = '0;
  logic       src_ready, rd_valid, busy, swap_pulse;
  logic [4:0] rd_data;
  logic [7:0] run_count;

  int errors = 0;
  int checks = 0;

  // Reference model: what the display shows, and the run being captured.
  int shown[N];
  int pending[N];
  bit loaded = 1'b0;
  int runs = 0;

  plot_frame_scheduler dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .run_req    (run_req),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .swap_pulse (swap_pulse),
    .run_count  (run_count)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic int exp_rd_data(input int col);
    return (col < N && loaded) ? shown[col] : 0;
  endfunction

  function automatic int exp_rd_valid(input int col);
    return (col < N && loaded) ? 1 : 0;
  endfunction

  task automatic do_read(input int col);
    int ed, ev;
    rd_col = 9'(col);
    ed = exp_rd_data(col);
    ev = exp_rd_valid(col);
    tick;
    check("rd_data", rd_data, ed);
    check("rd_valid", rd_valid, ev);
  endtask

  // Captures a run. mode 0: idx%10, 1: all 31, 2: random. Stops after abort_at accepts.
  task automatic fill(input int mode, input bit stall, input int abort_at, input bit fs_last,
                      output int ready_cycles);
    int idx, guard, pcol, v;
    bit acc;
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    idx = 0;
    guard = 0;
    ready_cycles = 0;
    while (idx < abort_at && guard < 4000) begin
      v = (mode == 0) ? idx % 10 : (mode == 1) ? 31 : int'($urandom_range(0, 31));
      src_valid   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_data    = 5'(v);
      frame_start = (fs_last && idx == N - 1) ? 1'b1 : ($urandom_range(0, 15) == 0);
      run_req     = ($urandom_range(0, 15) == 0);
      pcol        = int'($urandom_range(0, 310));
      rd_col      = 9'(pcol);
      #1;
      check("swap_in_fill", swap_pulse, 0);
      if (src_ready) ready_cycles++;
      acc = src_valid && src_ready;
      if (acc) pending[idx] = (v > MAXV) ? MAXV : v;
      tick;
      check("rd_data_in_fill", rd_data, exp_rd_data(pcol));
      check("rd_valid_in_fill", rd_valid, exp_rd_valid(pcol));
      if (acc) idx++;
      guard++;
    end
    src_valid   = 1'b0;
    frame_start = 1'b0;
    run_req     = 1'b0;
    check("fill_accepts", idx, abort_at);
    if (abort_at == N) begin
      #1;
      check("ready_dropped", src_ready, 0);
      check("busy_armed", busy, 1);
      check("count_before_swap", run_count, runs);
    end
  endtask

  // Pulses frame_start (with a coincident run_req) while reading a random column.
  task automatic do_frame(input bit exp_swap);
    int col, ed, ev;
    col = int'($urandom_range(0, 305));
    rd_col = 9'(col);
    ed = exp_rd_data(col);
    ev = exp_rd_valid(col);
    frame_start = 1'b1;
    run_req = 1'b1;
    #1;
    check("swap_pulse", swap_pulse, exp_swap);
    tick;
    frame_start = 1'b0;
    run_req = 1'b0;
    check("rd_data_swap_cycle", rd_data, ed);
    check("rd_valid_swap_cycle", rd_valid, ev);
    if (exp_swap) begin
      shown  = pending;
      loaded = 1'b1;
      runs   = (runs + 1) % 256;
    end
    #1;
    check("swap_one_cycle", swap_pulse, 0);
    check("run_count", run_count, runs);
    check("busy_after_frame", busy, exp_swap ? 0 : 1);
  endtask

  initial begin
    int rc;
    for (int i = 0; i < N; i++) begin
      shown[i] = 0;
      pending[i] = 0;
    end

    // Reset and post-reset state.
    repeat (3) tick;
    rst_n = 1'b1;
    do_read(5);
    check("reset_busy", busy, 0);
    check("reset_run_count", run_count, 0);
    check("reset_src_ready", src_ready, 0);
    check("reset_swap", swap_pulse, 0);

    // frame_start in IDLE is ignored.
    frame_start = 1'b1;
    #1;
    check("idle_fs_swap", swap_pulse, 0);
    tick;
    frame_start = 1'b0;
    check("idle_fs_busy", busy, 0);
    check("idle_fs_count", run_count, 0);

    // Basic run, src_valid held high.
    fill(0, 1'b0, N, 1'b0, rc);
    check("ready_cycles", rc, N);
    // Armed: no swap without frame_start, run_req not queued.
    for (int i = 0; i < 5; i++) begin
      run_req = (i == 2);
      #1;
      check("armed_ready", src_ready, 0);
      check("armed_swap", swap_pulse, 0);
      tick;
    end
    run_req = 1'b0;
    do_frame(1'b1);
    do_read(17);
    check("basic_col17", rd_data, 7);

    // Clamp and range.
    fill(1, 1'b1, N, 1'b0, rc);
    do_frame(1'b1);
    do_read(0);
    check("clamp_col0", rd_data, MAXV);
    do_read(300);
    do_read(17);

    // Tear-free: random frame_start pulses and reads during the fill.
    fill(2, 1'b1, N, 1'b0, rc);
    do_frame(1'b1);

    // frame_start coincident with the last accept is ignored.
    fill(2, 1'b0, N, 1'b1, rc);
    do_frame(1'b1);
    for (int i = 0; i < 8; i++) do_read(int'($urandom_range(0, 305)));

    // Mid-run reset discards the partial run.
    fill(0, 1'b1, 150, 1'b0, rc);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    loaded = 1'b0;
    runs = 0;
    check("midreset_ready", src_ready, 0);
    check("midreset_busy", busy, 0);
    check("midreset_count", run_count, 0);
    do_read(17);
    fill(2, 1'b1, N, 1'b0, rc);
    do_frame(1'b1);
    for (int i = 0; i < 8; i++) do_read(int'($urandom_range(0, 305)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plot_frame_scheduler.md
Name: plot_frame_scheduler

Overview:
- Frame-synchronous scheduler for the 300-column scatter-plot datapath.
- Accepts a run of samples from an upstream source (valid/ready) into a back buffer.
- Swaps back/front buffers only at a frame boundary, so the display never shows a half-written run (tear-free).
- Serves per-column reads from the front buffer to the pixel renderer.

Parameters:
- NUM_SAMPLES, 300, samples per run (one per plot column).
- SAMPLE_W, 5, sample value width in bits.
- COL_W, 9, column index width (must cover NUM_SAMPLES-1).
- MAX_VAL, 29, largest plottable value; larger inputs are clamped to it.

Ports:
- CLK100MHZ  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low. Clock is CLK100MHZ.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- run_req  in  1  request to capture a new run.
- src_data  in  SAMPLE_W  upstream sample.
- src_valid  in  1  upstream sample valid.
- src_ready  out  1  block accepts a sample this cycle.
- rd_col  in  COL_W  column index requested by renderer.
- rd_data  out  SAMPLE_W  front-buffer sample; 1-cycle latency.
- rd_valid  out  1  rd_data meaningful; 1-cycle latency.
- busy  out  1  high in FILL or ARMED.
- swap_pulse  out  1  one-cycle pulse when buffers swap.
- run_count  out  8  completed (swapped) runs; wraps 255->0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, wr_idx=0, bank_sel=0, loaded=0.
  - All outputs 0. RAM contents are not cleared.
- State IDLE:
  - src_ready=0.
  - run_req=1 -> FILL next cycle, wr_idx=0.
- State FILL:
  - src_ready=1.
  - On each src_valid&&src_ready, write min(src_data,MAX_VAL) to back bank (~bank_sel) at wr_idx, then wr_idx++.
  - The write at wr_idx==NUM_SAMPLES-1 moves to ARMED next cycle. src_ready drops the cycle after the last accept.
  - src_valid=0 cycles stall without penalty.
- State ARMED:
  - src_ready=0; waits for frame_start.
  - On frame_start: bank_sel toggles, loaded=1, swap_pulse=1 for exactly one cycle, run_count++, then IDLE.
- Boundary and simultaneous-event rules:
  - frame_start in IDLE or FILL is ignored.
  - frame_start coincident with the last FILL write is ignored; the swap waits for the next frame_start.
  - run_req outside IDLE is ignored, not queued.
  - run_req coincident with swap_pulse is ignored (state is ARMED that cycle).
  - Reset mid-FILL or ARMED discards the partial run. The front bank selection returns to bank 0 and loaded=0.
- busy = (state!=IDLE), registered with the state.
- Read port:
  - rd_data <= (rd_col<NUM_SAMPLES && loaded) ? front[rd_col] : 0.
  - rd_valid <= (rd_col<NUM_SAMPLES && loaded).
  - The read on the swap cycle itself uses the old front bank. The new bank is visible from the next cycle.

Optional Feature:
- Macro: PLOT_AUTO_RUN_EN.
- Defined: an internal run request is raised on the first cycle after reset releases and on every swap_pulse cycle, so IDLE is left on the next cycle. This gives continuous refresh, and external run_req is still honoured in IDLE.
- Undefined: runs start only from external run_req.

Decomposition:
- Package plot_pkg holds:
  - NUM_SAMPLES, SAMPLE_W, COL_W, MAX_VAL defaults.
  - State enum {IDLE, FILL, ARMED}.
- One sub-module, plot_sample_bank: simple dual-port RAM, depth NUM_SAMPLES, 1 sync write port, 1 sync read port (1-cycle read).
  - Instantiated twice (bank 0 and bank 1).
  - The read mux selects by bank_sel delayed to align with RAM latency.

Test Plan:
- Post-reset read: release reset, rd_col=5 -> rd_valid=0, rd_data=0, busy=0, run_count=0.
- Basic run: run_req pulse; feed values t%10 for t=0..299 with src_valid held high.
  - src_ready high exactly 300 cycles.
  - frame_start -> swap_pulse one cycle, run_count=1.
  - rd_col=17 -> rd_data=7, rd_valid=1.
- Clamp and range: feed all samples = 31.
  - After swap, rd_col=0 -> rd_data=29.
  - rd_col=300 -> rd_data=0, rd_valid=0.
- Tear-free: during a second run's FILL, pulse frame_start and read rd_col=17.
  - Returns the first-run value.
  - No swap_pulse, run_count stays 1.
- Coincident events: frame_start on the same cycle as the 300th accept -> no swap. The next frame_start -> swap, run_count increments.
- Mid-run reset: reset after 150 accepts -> state IDLE, src_ready=0, rd_valid=0, run_count=0. A full new run then swaps normally.
